class_score_sequencer: RTL and testbench

- Time-multiplexes the single shared `counter_adder` across all output classes of the classifier, then reports the winning class.
- Per class:
  - drives the class index to the bucket-count bank, which steers that class's 13 bucket counts into the adder;
  - issues one class per cycle, fully pipelined.
- Captures each 8-bit score after the adder latency and keeps a running argmax.
- Returns the predicted digit through a valid/ready result port.

---
 rtl/class_score_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_class_score_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/class_score_sequencer.sv
// -----------------------------------------------------------------------------
// class_score_sequencer
//
// Shares one counter_adder across every output class of the classifier. One
// class index is issued per cycle, so the issues are fully pipelined. The
// adder score for each class comes back LATENCY cycles after its issue. The
// sequencer keeps a running argmax of those scores and presents the winning
// class on a valid/ready result port.
//
// Optional build macro: CLASS_SCORE_DUMP_EN
//   When defined, every captured score is also kept in a NUM_CLASSES-entry
//   register file. That file is read combinationally through score_rd_addr
//   and score_rd_data.
//
// Ports:
//   clk           in   clock, all logic on the rising edge
//   rst_n         in   synchronous active-low reset
//   start         in   request one inference (taken in IDLE, or in DONE
//                      together with result_ready)
//   busy          out  high from the cycle after start is accepted until the
//                      result handshake completes
//   cls_idx       out  class index steering the bucket-count mux into the adder
//   cls_valid     out  high in every cycle cls_idx is a live issue
//   score_in      in   adder output, valid LATENCY cycles after its issue
//   result_valid  out  result available, held until result_ready
//   result_ready  in   consumer accepts the result
//   result_class  out  argmax class index
//   result_score  out  score of the argmax class
//   score_rd_addr in   (CLASS_SCORE_DUMP_EN only) score register-file address
//   score_rd_data out  (CLASS_SCORE_DUMP_EN only) score at score_rd_addr,
//                      0 when the address is out of range
// -----------------------------------------------------------------------------
module class_score_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int LATENCY     = 2,
  parameter int SCORE_W     = 8,
  parameter int IDX_W       = 4   // 2**IDX_W must cover NUM_CLASSES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic [IDX_W-1:0]   cls_idx,
  output logic               cls_valid,
  input  logic [SCORE_W-1:0] score_in,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [IDX_W-1:0]   result_class,
  output logic [SCORE_W-1:0] result_score
`ifdef CLASS_SCORE_DUMP_EN
  ,
  input  logic [IDX_W-1:0]   score_rd_addr,
  output logic [SCORE_W-1:0] score_rd_data
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]     cap_cnt_q, cap_cnt_d;
  logic [LATENCY-1:0]   vld_sr_q, vld_sr_d;
  logic [SCORE_W-1:0]   max_score_q, max_score_d;
  logic [IDX_W-1:0]     max_idx_q, max_idx_d;
  logic                 launch;
  logic                 cap_fire;

  // The delayed copy of cls_valid marks the cycle in which score_in belongs
  // to capture number cap_cnt_q.
  assign cap_fire = vld_sr_q[LATENCY-1];

  // Control: next-state logic and issue counter
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    launch      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          launch  = 1'b1;
        end
      end
      S_ISSUE: begin
        // The counter stops on the last class so cls_idx holds it in DRAIN.
        if (issue_cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cap_fire && (cap_cnt_q == LAST_IDX)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          if (start) begin
            state_d = S_ISSUE;   // back-to-back inference, no IDLE bubble
            launch  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      issue_cnt_d = '0;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign cls_valid    = (state_q == S_ISSUE);
  assign result_valid = (state_q == S_DONE);
  assign cls_idx      = issue_cnt_q;
  assign result_class = max_idx_q;
  assign result_score = max_score_q;

  // Capture path: valid delay line, capture counter and running argmax
  always_comb begin
    vld_sr_d    = '0;
    cap_cnt_d   = cap_cnt_q;
    max_score_d = max_score_q;
    max_idx_d   = max_idx_q;

    vld_sr_d[0] = cls_valid;
    for (int i = 1; i < LATENCY; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end

    if (cap_fire) begin
      cap_cnt_d = cap_cnt_q + 1'b1;
      // The first capture loads the max unconditionally. After that, the max
      // is replaced only on a strictly larger score, so ties keep the lower
      // class index.
      if ((cap_cnt_q == '0) || (score_in > max_score_q)) begin
        max_score_d = score_in;
        max_idx_d   = cap_cnt_q;
      end
    end

    // The delay line is empty when a start is accepted, so launch never
    // collides with a capture.
    if (launch) begin
      cap_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      vld_sr_q    <= '0;
      max_score_q <= '0;
      max_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_sr_q    <= vld_sr_d;
      max_score_q <= max_score_d;
      max_idx_q   <= max_idx_d;
    end
  end

`ifdef CLASS_SCORE_DUMP_EN
  logic [SCORE_W-1:0] dump_q [NUM_CLASSES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        dump_q[i] <= '0;
      end
    end else if (cap_fire && (int'(cap_cnt_q) < NUM_CLASSES)) begin
      dump_q[cap_cnt_q] <= score_in;
    end
  end

  assign score_rd_data = (int'(score_rd_addr) < NUM_CLASSES) ? dump_q[score_rd_addr] : '0;
`endif

endmodule

// File: tb/tb_class_score_sequencer.sv
// -----------------------------------------------------------------------------
// tb_class_score_sequencer
//
// Directed bench for class_score_sequencer. A small adder model returns a
// per-class score LATENCY cycles after each issue. Stimulus pushes the
// hand-computed expected result into a queue. A separate monitor pops the
// queue and compares on every result handshake. A second monitor checks that
// each issue burst counts 0..NUM_CLASSES-1.
// -----------------------------------------------------------------------------
module tb_class_score_sequencer;

  localparam int N  = 10;
  localparam int L  = 2;
  localparam int SW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic [IW-1:0] cls_idx;
  logic          cls_valid;
  logic [SW-1:0] score_in;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] result_class;
  logic [SW-1:0] result_score;
`ifdef CLASS_SCORE_DUMP_EN
  logic [IW-1:0] score_rd_addr = '0;
  logic [SW-1:0] score_rd_data;
`endif

  always #5 clk = ~clk;

  class_score_sequencer #(
    .NUM_CLASSES(N),
    .LATENCY    (L),
    .SCORE_W    (SW),
    .IDX_W      (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .cls_idx      (cls_idx),
    .cls_valid    (cls_valid),
    .score_in     (score_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score)
`ifdef CLASS_SCORE_DUMP_EN
    ,
    .score_rd_addr(score_rd_addr),
    .score_rd_data(score_rd_data)
`endif
  );

  // Adder model: the score for an issue appears two cycles after it.
  logic [SW-1:0] scores [16];
  logic [IW:0]   p0 = '0;
  logic [IW:0]   p1 = '0;
  always @(posedge clk) begin
    p0 <= {cls_valid, cls_idx};
    p1 <= p0;
  end
  assign score_in = p1[IW] ? scores[p1[IW-1:0]] : '0;

  int checks   = 0;
  int failures = 0;
  int q_cls [$];
  int q_sc  [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: compares on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (result_valid && result_ready) begin
        if (q_cls.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got class %0d score %0d with nothing expected",
                   result_class, result_score);
        end else begin
          check("result_class", int'(result_class), q_cls.pop_front());
          check("result_score", int'(result_score), q_sc.pop_front());
        end
      end
    end
  end

  // Issue monitor: every burst of cls_valid must count 0,1,2,...
  initial begin
    bit prev_v;
    int exp_k;
    prev_v = 1'b0;
    exp_k  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (cls_valid) begin
        if (!prev_v) exp_k = 0;
        check("cls_idx", int'(cls_idx), exp_k);
        exp_k++;
      end
      prev_v = cls_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int basic  [N] = '{128, 130, 125, 140, 128,  90, 200, 128, 128, 199};
  int flat   [N] = '{150, 150, 150, 150, 150, 150, 150, 150, 150, 150};
  int tie    [N] = '{150, 160, 160, 100, 100, 100, 100, 100, 100, 100};
  int lastw  [N] = '{128, 128, 128, 128, 128, 128, 128, 128, 128, 210};
  int allmax [N] = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
  int peak3  [N] = '{120, 120, 120, 140, 120, 120, 120, 120, 120, 120};

  task automatic load(input int v [N]);
    for (int i = 0; i < 16; i++) scores[i] = '0;
    for (int i = 0; i < N; i++) scores[i] = SW'(v[i]);
  endtask

  // Entered at a negedge in cycle T0+1. Returns at the negedge where
  // result_valid is first seen, which should be cycle T0+13.
  task automatic wait_result();
    int n;
    n = 1;
    while (n < 40 && !result_valid) begin
      @(negedge clk);
      n++;
    end
    check("result_latency", n, N + L + 1);
  endtask

  task automatic start_and_wait(input int exp_cls, input int exp_sc);
    start = 1'b1;
    q_cls.push_back(exp_cls);
    q_sc.push_back(exp_sc);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_result();
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    #1;
    check("post_hs_busy", int'(busy), 0);
    check("post_hs_result_valid", int'(result_valid), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cls_valid"}, int'(cls_valid), 0);
    check({tag, "_cls_idx"}, int'(cls_idx), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_result_class"}, int'(result_class), 0);
    check({tag, "_result_score"}, int'(result_score), 0);
  endtask

  initial begin
    int rv_seen;
    rst_n        = 1'b0;
    start        = 1'b0;
    result_ready = 1'b0;
    load(basic);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero_outputs("reset");

    // Basic argmax
    load(basic);
    start_and_wait(6, 200);
`ifdef CLASS_SCORE_DUMP_EN
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      score_rd_addr = a[IW-1:0];
      #1;
      check("dump_rd", int'(score_rd_data), basic[a]);
    end
    @(negedge clk);
    score_rd_addr = 4'd12;
    #1;
    check("dump_rd_out_of_range", int'(score_rd_data), 0);
`endif
    handshake();

    // All equal scores: class 0 wins
    load(flat);
    start_and_wait(0, 150);
    handshake();

    // Tie between classes 1 and 2: the lower index wins
    load(tie);
    start_and_wait(1, 160);
    handshake();

    // Backpressure with start toggling while DONE
    load(lastw);
    start_and_wait(9, 210);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = i[0];
      #1;
      check("bp_result_valid", int'(result_valid), 1);
      check("bp_busy", int'(busy), 1);
      check("bp_cls_valid", int'(cls_valid), 0);
      check("bp_result_class", int'(result_class), 9);
      check("bp_result_score", int'(result_score), 210);
    end
    @(negedge clk);
    start = 1'b0;
    handshake();
    repeat (3) @(negedge clk);

    // Back-to-back: start together with result_ready in DONE
    load(allmax);
    start_and_wait(0, 255);
    load(peak3);
    start        = 1'b1;
    result_ready = 1'b1;
    q_cls.push_back(3);
    q_sc.push_back(140);
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    result_ready = 1'b0;
    #1;
    check("b2b_cls_valid", int'(cls_valid), 1);
    check("b2b_cls_idx", int'(cls_idx), 0);
    check("b2b_busy", int'(busy), 1);
    wait_result();
    handshake();

    // Reset during cycle T0+5 abandons the inference
    load(basic);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero_outputs("midreset");
    rv_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("midreset_no_result", rv_seen, 0);

    // A clean inference after the abandoned one
    load(tie);
    start_and_wait(1, 160);
    handshake();

    repeat (2) @(negedge clk);
    check("pending_results", q_cls.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
